// File: rtl/mem_arbiter_n_pkg.sv
// rtl/mem_arbiter_n_pkg.sv - shared types and width helpers for the N-master memory arbiter
//
// Purpose: FSM state encoding and the width helpers used by the arbiter
// top and its winner picker.

package mem_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Width of a master index; a single master still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the BUSY timeout counter; kept at least one bit when disabled.
    function automatic int tcnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_pick.sv
// rtl/mem_arbiter_n_rr_pick.sv - combinational fixed/round-robin winner picker
//
// Purpose: choose one requester out of N, either lowest index first or
// searching upward from the master after last_grant with wrap-around.
// Ports:
//   req        in   N       active requests
//   last_grant in   IDX_W   index of the previous winner
//   rr_mode    in   1       0 = fixed priority, 1 = round-robin
//   winner     out  N       one-hot winner, 0 when no request
//   winner_idx out  IDX_W   binary index of the winner
//   found      out  1       at least one request present

module mem_arbiter_n_rr_pick
    import mem_arbiter_n_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             rr_mode,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    always_comb begin
        int start;
        int cand;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        start      = 0;
        cand       = 0;
        if (rr_mode) begin
            start = int'(last_grant) + 1;
            if (start >= N) begin
                start = 0;
            end
        end
        // Walk candidates in priority order; the inner loop keeps every
        // vector index constant so no variable bit-select is needed.
        for (int i = 0; i < N; i++) begin
            cand = start + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!found && j == cand && req[j]) begin
                    found      = 1'b1;
                    winner[j]  = 1'b1;
                    winner_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-master to one-slave memory arbiter with wait states and timeout
//
// Purpose: arbitrate N bus masters onto one memory slave using a
// three-phase IDLE -> BUSY -> RESP protocol, fixed or round-robin priority,
// slave wait states and an optional BUSY timeout that answers with an error.
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   m_htrans/haddr/hwrite/hwdata  per-master requests (packed, master i at slice i)
//   m_hrdata        shared read data; m_hready/m_herr one-cycle per-master pulses
//   grant           one-hot current owner; stall = any request not completing now
//   s_htrans/haddr/hwrite/hwdata  slave request; s_hrdata/s_hready slave response

module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [N_MASTERS-1:0]          m_htrans,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_haddr,
    input  logic [N_MASTERS-1:0]          m_hwrite,
    input  logic [N_MASTERS*DATA_W-1:0]   m_hwdata,
    output logic [DATA_W-1:0]             m_hrdata,
    output logic [N_MASTERS-1:0]          m_hready,
    output logic [N_MASTERS-1:0]          m_herr,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          stall,
    output logic                          s_htrans,
    output logic [ADDR_W-1:0]             s_haddr,
    output logic                          s_hwrite,
    output logic [DATA_W-1:0]             s_hwdata,
    input  logic [DATA_W-1:0]             s_hrdata,
    input  logic                          s_hready
);

    localparam int IDX_W  = idx_width(N_MASTERS);
    localparam int TCNT_W = tcnt_width(TIMEOUT);
    localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_MASTERS - 1);

    arb_state_t             state;
    arb_state_t             next_state;
    logic [N_MASTERS-1:0]   grant_q;
    logic [IDX_W-1:0]       last_grant;
    logic                   err_q;
    logic [TCNT_W-1:0]      tcount;
    logic                   timeout_hit;

    logic [N_MASTERS-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_write;

    mem_arbiter_n_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (m_htrans),
        .last_grant (last_grant),
        .rr_mode    (RR_MODE != 0),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    // One-hot mux of the winning master's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick_onehot[i]) begin
                sel_addr  = m_haddr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_hwdata[i*DATA_W +: DATA_W];
                sel_write = m_hwrite[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real completion wins over a timeout landing in the same cycle.
                if (s_hready) begin
                    next_state = ST_RESP;
                end else if (TIMEOUT != 0 && tcount == TO_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_q    <= '0;
            last_grant <= LAST_RST;
            err_q      <= 1'b0;
            tcount     <= '0;
            m_hrdata   <= '0;
            s_haddr    <= '0;
            s_hwrite   <= 1'b0;
            s_hwdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_onehot;
                        last_grant <= pick_idx;
                        s_haddr    <= sel_addr;
                        s_hwrite   <= sel_write;
                        s_hwdata   <= sel_wdata;
                        err_q      <= 1'b0;
                        tcount     <= '0;
                    end
                end
                ST_BUSY: begin
                    if (s_hready) begin
                        m_hrdata <= s_hwrite ? '0 : s_hrdata;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        m_hrdata <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        tcount <= tcount + TCNT_W'(1);
                    end
                end
                ST_RESP: begin
                    grant_q <= '0;
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Response pulses decode registered state only, so they cannot glitch.
    assign grant    = grant_q;
    assign m_hready = (state == ST_RESP) ? grant_q : '0;
    assign m_herr   = (state == ST_RESP && err_q) ? grant_q : '0;
    assign s_htrans = (state == ST_BUSY);
    assign stall    = |(m_htrans & ~m_hready);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - directed self-checking bench for mem_arbiter_n

module tb_mem_arbiter_n;

    logic         CLK;
    logic         RESET;

    logic [1:0]   m_htrans;
    logic [63:0]  m_haddr;
    logic [1:0]   m_hwrite;
    logic [63:0]  m_hwdata;
    logic [31:0]  s_hrdata;
    logic         s_hready;

    logic [31:0]  r_m_hrdata;
    logic [1:0]   r_m_hready, r_m_herr, r_grant;
    logic         r_stall, r_s_htrans, r_s_hwrite;
    logic [31:0]  r_s_haddr, r_s_hwdata;

    logic [31:0]  f_m_hrdata;
    logic [1:0]   f_m_hready, f_m_herr, f_grant;
    logic         f_stall, f_s_htrans, f_s_hwrite;
    logic [31:0]  f_s_haddr, f_s_hwdata;

    logic [3:0]   q_htrans;
    logic [127:0] q_haddr;
    logic [3:0]   q_hwrite;
    logic [127:0] q_hwdata;
    logic [31:0]  q_s_hrdata;
    logic         q_s_hready;
    logic [31:0]  q_m_hrdata;
    logic [3:0]   q_m_hready, q_m_herr, q_grant;
    logic         q_stall, q_s_htrans, q_s_hwrite;
    logic [31:0]  q_s_haddr, q_s_hwdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter_n #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(4)) dut_rr (
        .CLK(CLK), .RESET(RESET),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
        .m_hrdata(r_m_hrdata), .m_hready(r_m_hready), .m_herr(r_m_herr), .grant(r_grant),
        .stall(r_stall), .s_htrans(r_s_htrans), .s_haddr(r_s_haddr), .s_hwrite(r_s_hwrite),
        .s_hwdata(r_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready)
    );

    mem_arbiter_n #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(4)) dut_fx (
        .CLK(CLK), .RESET(RESET),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
        .m_hrdata(f_m_hrdata), .m_hready(f_m_hready), .m_herr(f_m_herr), .grant(f_grant),
        .stall(f_stall), .s_htrans(f_s_htrans), .s_haddr(f_s_haddr), .s_hwrite(f_s_hwrite),
        .s_hwdata(f_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready)
    );

    mem_arbiter_n #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(16)) dut_q (
        .CLK(CLK), .RESET(RESET),
        .m_htrans(q_htrans), .m_haddr(q_haddr), .m_hwrite(q_hwrite), .m_hwdata(q_hwdata),
        .m_hrdata(q_m_hrdata), .m_hready(q_m_hready), .m_herr(q_m_herr), .grant(q_grant),
        .stall(q_stall), .s_htrans(q_s_htrans), .s_haddr(q_s_haddr), .s_hwrite(q_s_hwrite),
        .s_hwdata(q_s_hwdata), .s_hrdata(q_s_hrdata), .s_hready(q_s_hready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    logic [1:0] rr_exp [4];
    logic [1:0] fx_exp;

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        fx_exp = 2'b01;
        RESET = 1'b1;
        m_htrans = '0; m_haddr = '0; m_hwrite = '0; m_hwdata = '0;
        s_hrdata = '0; s_hready = 1'b0;
        q_htrans = '0; q_haddr = '0; q_hwrite = '0; q_hwdata = '0;
        q_s_hrdata = '0; q_s_hready = 1'b0;
        cyc(2);
        check_val("rst_grant", r_grant, 2'b00);
        check_val("rst_hready", r_m_hready, 2'b00);
        check_val("rst_s_htrans", r_s_htrans, 1'b0);
        check_val("rst_s_haddr", r_s_haddr, 32'h0);
        check_val("rst_hrdata", r_m_hrdata, 32'h0);
        RESET = 1'b0;

        // Single master 0 read, zero-wait slave
        m_htrans = 2'b01; m_haddr[0 +: 32] = 32'h100; s_hready = 1'b1; s_hrdata = 32'hDEAD;
        cyc(1);
        check_val("rd_grant_c1", r_grant, 2'b01);
        check_val("rd_s_htrans_c1", r_s_htrans, 1'b1);
        check_val("rd_s_haddr_c1", r_s_haddr, 32'h100);
        check_val("rd_hready_c1", r_m_hready, 2'b00);
        check_val("rd_stall_c1", r_stall, 1'b1);
        cyc(1);
        check_val("rd_hready_c2", r_m_hready, 2'b01);
        check_val("rd_hrdata_c2", r_m_hrdata, 32'hDEAD);
        check_val("rd_grant_c2", r_grant, 2'b01);
        check_val("rd_stall_c2", r_stall, 1'b0);
        m_htrans = 2'b00;
        cyc(1);
        check_val("rd_idle_grant", r_grant, 2'b00);

        // Timeout: slave never ready, four BUSY cycles then error response
        m_htrans = 2'b01; m_haddr[0 +: 32] = 32'h140; s_hready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            check_val($sformatf("to_s_htrans_%0d", c), r_s_htrans, 1'b1);
            check_val($sformatf("to_hready_%0d", c), r_m_hready, 2'b00);
        end
        cyc(1);
        check_val("to_hready", r_m_hready, 2'b01);
        check_val("to_herr", r_m_herr, 2'b01);
        check_val("to_hrdata", r_m_hrdata, 32'h0);
        check_val("to_s_htrans", r_s_htrans, 1'b0);
        m_htrans = 2'b00;
        cyc(1);
        check_val("to_idle_grant", r_grant, 2'b00);
        check_val("to_herr_clr", r_m_herr, 2'b00);

        // Both masters requesting continuously: RR alternates, fixed starves master 1
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        m_htrans = 2'b11; s_hready = 1'b1; s_hrdata = 32'h77;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check_val($sformatf("rr_grant_%0d", k), r_grant, rr_exp[k]);
            check_val($sformatf("fx_grant_%0d", k), f_grant, fx_exp);
            cyc(1);
            check_val($sformatf("rr_hready_%0d", k), r_m_hready, rr_exp[k]);
            cyc(1);
        end
        m_htrans = 2'b00;
        cyc(1);

        // Master 1 write with three wait states; address change while granted ignored
        m_htrans = 2'b10; m_haddr[32 +: 32] = 32'h200; m_hwrite = 2'b10;
        m_hwdata[32 +: 32] = 32'h55; s_hready = 1'b0; s_hrdata = 32'h1234;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            check_val($sformatf("wr_s_htrans_%0d", c), r_s_htrans, 1'b1);
            check_val($sformatf("wr_s_hwrite_%0d", c), r_s_hwrite, 1'b1);
            check_val($sformatf("wr_s_hwdata_%0d", c), r_s_hwdata, 32'h55);
            check_val($sformatf("wr_s_haddr_%0d", c), r_s_haddr, 32'h200);
            check_val($sformatf("wr_hready_%0d", c), r_m_hready, 2'b00);
            if (c == 2) m_haddr[32 +: 32] = 32'h999;
            if (c == 4) s_hready = 1'b1;
        end
        cyc(1);
        check_val("wr_hready", r_m_hready, 2'b10);
        check_val("wr_herr", r_m_herr, 2'b00);
        check_val("wr_hrdata", r_m_hrdata, 32'h0);
        check_val("wr_s_htrans_resp", r_s_htrans, 1'b0);
        m_htrans = 2'b00; m_hwrite = 2'b00;
        cyc(1);

        // Reset in the middle of BUSY: no response pulse, master 0 first afterwards
        m_htrans = 2'b10; m_haddr[32 +: 32] = 32'h300; s_hready = 1'b0;
        cyc(1);
        check_val("mr_grant_busy", r_grant, 2'b10);
        RESET = 1'b1;
        cyc(1);
        check_val("mr_grant", r_grant, 2'b00);
        check_val("mr_hready", r_m_hready, 2'b00);
        check_val("mr_s_htrans", r_s_htrans, 1'b0);
        check_val("mr_s_haddr", r_s_haddr, 32'h0);
        check_val("mr_s_hwrite", r_s_hwrite, 1'b0);
        cyc(1);
        check_val("mr_hready_hold", r_m_hready, 2'b00);
        RESET = 1'b0;
        m_htrans = 2'b11; s_hready = 1'b1;
        cyc(1);
        check_val("mr_first_grant", r_grant, 2'b01);
        cyc(2);
        m_htrans = 2'b00;

        // Four masters, RR: serve master 1, then requests {3,1} give 3 then 1
        q_htrans = 4'b0010; q_s_hready = 1'b1;
        cyc(1);
        check_val("q_grant_m1", q_grant, 4'b0010);
        cyc(1);
        check_val("q_hready_m1", q_m_hready, 4'b0010);
        q_htrans = 4'b1010;
        cyc(1);
        check_val("q_idle_grant", q_grant, 4'b0000);
        check_val("q_stall_idle", q_stall, 1'b1);
        cyc(1);
        check_val("q_grant_m3", q_grant, 4'b1000);
        check_val("q_stall_busy", q_stall, 1'b1);
        cyc(1);
        check_val("q_hready_m3", q_m_hready, 4'b1000);
        check_val("q_stall_resp3", q_stall, 1'b1);
        q_htrans = 4'b0010;
        cyc(1);
        check_val("q_stall_idle2", q_stall, 1'b1);
        cyc(1);
        check_val("q_grant_m1b", q_grant, 4'b0010);
        cyc(1);
        check_val("q_hready_m1b", q_m_hready, 4'b0010);
        check_val("q_stall_done", q_stall, 1'b0);
        q_htrans = 4'b0000;
        cyc(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
